rtl_logic_primitives: RTL and testbench

Training/bring-up block that groups the basic RTL primitives in one module: a resettable D flip-flop, a 2:1 multiplexer and two bitwise gates (AND, OR). It is used as a first-silicon sanity target on the board and as the reference for synthesis/simulation flow checks. All datapaths are WIDTH bits wide; the default is single-bit.

---
 rtl/rtl_logic_primitives.sv | 78 +++++++
 tb/tb_rtl_logic_primitives.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/rtl_logic_primitives.sv
// Basic RTL primitives: a resettable D flip-flop, a 2:1 mux, and bitwise AND/OR gates.
// Define REG_OUT_EN to register sel_o, x and y so they have the same one-cycle latency as q.
module rtl_logic_primitives #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] sel_o,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] sel_c;
  logic [WIDTH-1:0] x_c;
  logic [WIDTH-1:0] y_c;

  always_comb begin
    q_d   = d;
    sel_c = s ? b : a;
    x_c   = a & b;
    y_c   = a | b;
  end

  // reset is active-low and only takes effect on a clock edge
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

`ifdef REG_OUT_EN
  logic [WIDTH-1:0] sel_o_d;
  logic [WIDTH-1:0] sel_o_q;
  logic [WIDTH-1:0] x_d;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_d;
  logic [WIDTH-1:0] y_q;

  always_comb begin
    sel_o_d = sel_c;
    x_d     = x_c;
    y_d     = y_c;
  end

  // registered outputs clear together with q
  always_ff @(posedge clk) begin
    if (!reset) begin
      sel_o_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      sel_o_q <= sel_o_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign sel_o = sel_o_q;
  assign x     = x_q;
  assign y     = y_q;
`else
  assign sel_o = sel_c;
  assign x     = x_c;
  assign y     = y_c;
`endif

endmodule

// File: tb/tb_rtl_logic_primitives.sv
// Directed-vector bench for rtl_logic_primitives; follows REG_OUT_EN when it is defined.
module tb_rtl_logic_primitives;
  localparam int W = 1;

  logic         clk;
  logic         reset;
  logic [W-1:0] d;
  logic [W-1:0] q;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         s;
  logic [W-1:0] sel_o;
  logic [W-1:0] x;
  logic [W-1:0] y;

  int n_vec;
  int n_bad;

  rtl_logic_primitives #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .d     (d),
    .q     (q),
    .a     (a),
    .b     (b),
    .s     (s),
    .sel_o (sel_o),
    .x     (x),
    .y     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // combinational outputs settle after #1; registered outputs need an edge
  task automatic settle();
`ifdef REG_OUT_EN
    tick();
`else
    #1;
`endif
  endtask

  logic [1:0] pat [4];
  logic [3:0] exp_x;
  logic [3:0] exp_y;
  logic [3:0] exp_m0;
  logic [3:0] exp_m1;
  logic [W-1:0] prev_q;

  initial begin
    n_vec = 0;
    n_bad = 0;
    // pattern order {a,b}: 00, 10, 01, 11
    pat[0] = 2'b00; pat[1] = 2'b10; pat[2] = 2'b01; pat[3] = 2'b11;
    exp_x  = 4'b1000;  // bit i = expected for pattern i
    exp_y  = 4'b1110;
    exp_m0 = 4'b1010;
    exp_m1 = 4'b1100;

    reset = 1'b0; d = 1'b1; a = '0; b = '0; s = 1'b0;

    // reset held for three edges with d=1
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("q_in_reset", 64'(q), 64'd0);
    end
    reset = 1'b1;
    #2;
    chk("q_release_before_edge", 64'(q), 64'd0);
    tick();
    chk("q_release_after_edge", 64'(q), 64'd1);

    // asserting reset mid-cycle must wait for the edge
    reset = 1'b0;
    #2;
    chk("q_reset_mid_cycle", 64'(q), 64'd1);
    tick();
    chk("q_reset_at_edge", 64'(q), 64'd0);
    reset = 1'b1;

    // dff tracking with glitches between edges
    prev_q = '0;
    for (int v = 0; v < 3; v++) begin
      for (int c = 0; c < 10; c++) begin
        d = W'(v == 1);
        #1 d = ~d;
        #1 d = W'(v == 1);
        chk("dff_hold", 64'(q), 64'(prev_q));
        tick();
        chk("dff_track", 64'(q), 64'(v == 1));
        prev_q = W'(v == 1);
      end
    end

    // gates and mux, s=0 then s=1
    for (int sv = 0; sv < 2; sv++) begin
      s = sv[0];
      for (int i = 0; i < 4; i++) begin
        a = W'(pat[i][1]);
        b = W'(pat[i][0]);
        settle();
        chk("and_x", 64'(x), 64'(exp_x[i]));
        chk("or_y", 64'(y), 64'(exp_y[i]));
        chk(sv == 0 ? "mux_s0" : "mux_s1", 64'(sel_o), 64'(sv == 0 ? exp_m0[i] : exp_m1[i]));
      end
    end

    // toggling s with a=1, b=0
    a = '1; b = '0; s = 1'b0;
    settle();
    chk("mux_toggle_s0", 64'(sel_o), 64'd1);
    s = 1'b1;
    settle();
    chk("mux_toggle_s1", 64'(sel_o), 64'd0);

    // behaviour of sel_o/x/y while reset is asserted
    a = '1; b = '1; s = 1'b0;
    settle();
    reset = 1'b0;
`ifdef REG_OUT_EN
    tick();
    chk("rst_sel_o", 64'(sel_o), 64'd0);
    chk("rst_x", 64'(x), 64'd0);
    chk("rst_y", 64'(y), 64'd0);
`else
    #1;
    chk("rst_sel_o", 64'(sel_o), 64'd1);
    chk("rst_x", 64'(x), 64'd1);
    chk("rst_y", 64'(y), 64'd1);
    a = '0;
    #1;
    chk("rst_sel_o_live", 64'(sel_o), 64'd0);
    chk("rst_y_live", 64'(y), 64'd1);
    tick();
`endif
    chk("rst_q", 64'(q), 64'd0);
    reset = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
